// File: rtl/conv33_bias_bank.sv
// conv33_bias_bank: per-channel bias store for the conv33 output stage.
// Biases are loaded sequentially through load_en/load_data and read back either
// in channel order (read_mode=0, internal read pointer) or by explicit channel
// address (read_mode=1, read_addr). Read latency is one cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_clr            restart load: clears both pointers and the loaded flag
//   load_en, load_data  write load_data at the write pointer
//   load_done           one-cycle pulse after the write to entry NUM_CH-1
//   loaded              all entries written since the last clear/reset
//   read_en, read_mode, read_addr   read request, mode, address (mode=1)
//   bias, ch_idx        registered bias word and its channel index
//   valid               one cycle per accepted read
//   last_ch             with valid on the sequential beat of channel NUM_CH-1
//   rd_err              one-cycle pulse on an illegal read
module conv33_bias_bank #(
    parameter int unsigned BIAS_WIDTH = 32,
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_clr,
    input  logic                  load_en,
    input  logic [BIAS_WIDTH-1:0] load_data,
    output logic                  load_done,
    output logic                  loaded,
    input  logic                  read_en,
    input  logic                  read_mode,
    input  logic [ADDR_W-1:0]     read_addr,
    output logic [BIAS_WIDTH-1:0] bias,
    output logic [ADDR_W-1:0]     ch_idx,
    output logic                  valid,
    output logic                  last_ch,
    output logic                  rd_err
);

    // Storage spans the full index range so any ADDR_W-bit index is in bounds;
    // only entries 0..NUM_CH-1 are ever written or legally read.
    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);

    logic [BIAS_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic                  loaded_q,    loaded_d;
    logic                  load_done_q, load_done_d;
    logic [BIAS_WIDTH-1:0] bias_q,      bias_d;
    logic [ADDR_W-1:0]     ch_idx_q,    ch_idx_d;
    logic                  valid_q,     valid_d;
    logic                  last_ch_q,   last_ch_d;
    logic                  rd_err_q,    rd_err_d;

    logic                  mem_we_c;
    logic [ADDR_W-1:0]     rd_sel_c;
    logic                  addr_bad_c;

    // Next-state logic for pointers, flags and the output registers.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        loaded_d    = loaded_q;
        load_done_d = 1'b0;
        bias_d      = bias_q;
        ch_idx_d    = ch_idx_q;
        valid_d     = 1'b0;
        last_ch_d   = 1'b0;
        rd_err_d    = 1'b0;
        mem_we_c    = 1'b0;
        rd_sel_c    = read_mode ? read_addr : rd_ptr_q;
        addr_bad_c  = read_mode && (32'(read_addr) >= NUM_CH);

        if (load_clr) begin
            // Clear wins over any same-cycle load or read.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            loaded_d = 1'b0;
        end else begin
            if (load_en) begin
                mem_we_c = 1'b1;
                if (wr_ptr_q == LAST_IDX) begin
                    wr_ptr_d    = '0;
                    load_done_d = 1'b1;
                    loaded_d    = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end

            if (read_en) begin
                if (!loaded_q || addr_bad_c) begin
                    rd_err_d = 1'b1;
                end else begin
                    // mem_q is read before this edge's write lands: old data wins.
                    valid_d  = 1'b1;
                    bias_d   = mem_q[rd_sel_c];
                    ch_idx_d = rd_sel_c;
                    if (!read_mode) begin
                        last_ch_d = (rd_ptr_q == LAST_IDX);
                        rd_ptr_d  = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            loaded_q    <= 1'b0;
            load_done_q <= 1'b0;
            bias_q      <= '0;
            ch_idx_q    <= '0;
            valid_q     <= 1'b0;
            last_ch_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            loaded_q    <= loaded_d;
            load_done_q <= load_done_d;
            bias_q      <= bias_d;
            ch_idx_q    <= ch_idx_d;
            valid_q     <= valid_d;
            last_ch_q   <= last_ch_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Bias storage, not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= load_data;
        end
    end

    assign load_done = load_done_q;
    assign loaded    = loaded_q;
    assign bias      = bias_q;
    assign ch_idx    = ch_idx_q;
    assign valid     = valid_q;
    assign last_ch   = last_ch_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_conv33_bias_bank.sv
// Testbench for conv33_bias_bank (NUM_CH=4, ADDR_W=3, BIAS_WIDTH=32).
// A driver applies directed then random stimulus and pushes expected responses
// from a behavioural model; a negedge monitor pops and compares.
module tb_conv33_bias_bank;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_clr = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_done;
    logic        loaded;
    logic        read_en = 1'b0;
    logic        read_mode = 1'b0;
    logic [2:0]  read_addr = '0;
    logic [31:0] bias;
    logic [2:0]  ch_idx;
    logic        valid;
    logic        last_ch;
    logic        rd_err;

    conv33_bias_bank #(.BIAS_WIDTH(32), .NUM_CH(NCH), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .load_clr(load_clr), .load_en(load_en), .load_data(load_data),
        .load_done(load_done), .loaded(loaded),
        .read_en(read_en), .read_mode(read_mode), .read_addr(read_addr),
        .bias(bias), .ch_idx(ch_idx), .valid(valid), .last_ch(last_ch),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned due;
        bit          err;
        logic [31:0] bias;
        logic [2:0]  ch;
        bit          last;
    } exp_t;

    exp_t        sbq[$];
    int unsigned doneq[$];

    // Behavioural model state.
    logic [31:0] m_mem [NCH];
    int          m_wr = 0;
    int          m_rd = 0;
    bit          m_loaded = 1'b0;
    logic [31:0] m_hold_bias = '0;
    logic [2:0]  m_hold_ch = '0;
    bit          exp_loaded = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // One clock of stimulus; the model predicts the response of this edge.
    task automatic step(input bit clr, input bit ld, input logic [31:0] d,
                        input bit rd, input bit mode, input logic [2:0] addr);
        exp_t e;
        int   ch;
        load_clr  = clr;
        load_en   = ld;
        load_data = d;
        read_en   = rd;
        read_mode = mode;
        read_addr = addr;
        if (clr) begin
            m_wr = 0;
            m_rd = 0;
            m_loaded = 1'b0;
        end else begin
            if (rd) begin
                e.due = edge_cnt + 1;
                if (!m_loaded || (mode && int'(addr) >= NCH)) begin
                    e.err = 1'b1; e.bias = m_hold_bias; e.ch = m_hold_ch; e.last = 1'b0;
                end else begin
                    ch = mode ? int'(addr) : m_rd;
                    e.err = 1'b0; e.bias = m_mem[ch]; e.ch = 3'(ch);
                    e.last = !mode && (ch == NCH - 1);
                    m_hold_bias = e.bias;
                    m_hold_ch = e.ch;
                    if (!mode) m_rd = (m_rd + 1) % NCH;
                end
                sbq.push_back(e);
            end
            if (ld) begin
                m_mem[m_wr] = d;
                if (m_wr == NCH - 1) begin
                    m_loaded = 1'b1;
                    doneq.push_back(edge_cnt + 1);
                end
                m_wr = (m_wr + 1) % NCH;
            end
        end
        @(posedge clk);
        #1;
        exp_loaded = m_loaded;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic model_reset();
        sbq.delete();
        doneq.delete();
        m_wr = 0; m_rd = 0; m_loaded = 1'b0;
        m_hold_bias = '0; m_hold_ch = '0;
        exp_loaded = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT presents an output.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("loaded", 64'(loaded), 64'(exp_loaded));
            if (valid || rd_err) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_out: valid=%0b rd_err=%0b want none (t=%0t)", valid, rd_err, $time);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_cycle", 64'(edge_cnt), 64'(mon_e.due));
                    chk("valid", 64'(valid), 64'(!mon_e.err));
                    chk("rd_err", 64'(rd_err), 64'(mon_e.err));
                    chk("bias", 64'(bias), 64'(mon_e.bias));
                    chk("ch_idx", 64'(ch_idx), 64'(mon_e.ch));
                    chk("last_ch", 64'(last_ch), 64'(mon_e.last));
                end
            end
            while (sbq.size() > 0 && sbq[0].due < edge_cnt) begin
                total++; bad++;
                $display("FAIL missing_out: got none want response due at edge %0d", sbq[0].due);
                void'(sbq.pop_front());
            end
            if (load_done) begin
                if (doneq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_load_done: got 1 want 0 (t=%0t)", $time);
                end else begin
                    chk("load_done_cycle", 64'(edge_cnt), 64'(doneq.pop_front()));
                end
            end
            while (doneq.size() > 0 && doneq[0] < edge_cnt) begin
                total++; bad++;
                $display("FAIL missing_load_done: got none want pulse at edge %0d", doneq[0]);
                void'(doneq.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seed_vals [4];
        seed_vals[0] = 32'h11; seed_vals[1] = 32'h22;
        seed_vals[2] = 32'h33; seed_vals[3] = 32'h44;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_bias", 64'(bias), 64'h0);
        chk("rst_ch_idx", 64'(ch_idx), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        chk("rst_last_ch", 64'(last_ch), 64'h0);
        chk("rst_rd_err", 64'(rd_err), 64'h0);
        chk("rst_load_done", 64'(load_done), 64'h0);
        chk("rst_loaded", 64'(loaded), 64'h0);
        @(posedge clk); #1;

        // Read before any load is illegal.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1);

        // Initial load of four entries.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seed_vals[i], 1'b0, 1'b0, 3'd0);
        idle(); idle();

        // Six back-to-back sequential reads, wrapping.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        // Addressed reads, then sequential continues from rd_ptr.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd2);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        // Out-of-range addressed read, then sequential read must be unmoved.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd5);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd4);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);

        // Same-cycle write and sequential read of ch 0: old data returned.
        step(1'b0, 1'b1, 32'hAA, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        idle();

        // Clear mid-load, with a colliding load and read.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 32'h66, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i + 1), 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0);
        idle();

        // Async reset mid-read clears outputs without waiting for a clock.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd2);
        chk("pre_rst_valid", 64'(valid), 64'h1);
        chk("pre_rst_bias", 64'(bias), 64'h3);
        model_reset();
        read_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(valid), 64'h0);
        chk("async_rst_bias", 64'(bias), 64'h0);
        chk("async_rst_ch_idx", 64'(ch_idx), 64'h0);
        chk("async_rst_loaded", 64'(loaded), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 55, $urandom,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                 3'($urandom_range(0, 7)));
        end
        idle(); idle(); idle();

        chk("drain_outputs", 64'(sbq.size()), 64'h0);
        chk("drain_load_done", 64'(doneq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
